// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory port, decode handshake and execute redirect.
// master = fetch unit, slave = memory/decode/execute environment.
interface instruction_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] instruction;
  logic [5:0]            opcode;
  logic [DATA_WIDTH-1:0] inst_pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_target;

  modport master (
    output imem_req, imem_addr, inst_valid, instruction, opcode, inst_pc, pc_plus4,
    input  imem_ack, imem_rdata, inst_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, instruction, opcode, inst_pc, pc_plus4,
    output imem_ack, imem_rdata, inst_ready, redirect, redirect_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch: one outstanding memory request, one output holding register,
// PC sequencing with branch/jump redirects from execute.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = 32'h0040_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] pending_target;
  logic [DATA_WIDTH-1:0] pending_next;
  logic [DATA_WIDTH-1:0] pc_inc;
  logic [DATA_WIDTH-1:0] target_aligned;
  logic                  load_inst;
  logic                  consume;

  logic                  inst_valid_q;
  logic [DATA_WIDTH-1:0] instruction_q;
  logic [DATA_WIDTH-1:0] inst_pc_q;
  logic [DATA_WIDTH-1:0] pc_plus4_q;

  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
    return {addr[DATA_WIDTH-1:2], 2'b00};
  endfunction

  assign pc_inc         = pc + DATA_WIDTH'(4);
  assign target_aligned = word_align(bus.redirect_target);

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending_target;
    load_inst    = 1'b0;
    consume      = 1'b0;
    unique case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (bus.imem_ack && bus.redirect) begin
          pc_next = target_aligned;
        end else if (bus.imem_ack) begin
          load_inst  = 1'b1;
          pc_next    = pc_inc;
          state_next = HOLD;
        end else if (bus.redirect) begin
          // The request already on the bus must complete before the new PC can be used
          pending_next = target_aligned;
          state_next   = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.imem_ack) begin
          pc_next    = bus.redirect ? target_aligned : pending_target;
          state_next = FETCH;
        end else if (bus.redirect) begin
          pending_next = target_aligned;
        end
      end
      HOLD: begin
        if (bus.redirect) begin
          pc_next    = target_aligned;
          consume    = 1'b1;
          state_next = FETCH;
        end else if (bus.inst_ready) begin
          consume    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      pc             <= PC_RESET;
      pending_target <= PC_RESET;
      inst_valid_q   <= 1'b0;
      instruction_q  <= '0;
      inst_pc_q      <= '0;
      pc_plus4_q     <= DATA_WIDTH'(4);
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      pending_target <= pending_next;
      if (load_inst) begin
        inst_valid_q  <= 1'b1;
        instruction_q <= bus.imem_rdata;
        inst_pc_q     <= pc;
        pc_plus4_q    <= pc_inc;
      end else if (consume) begin
        inst_valid_q  <= 1'b0;
      end
    end
  end

  // pc is not advanced while a request is outstanding, so it doubles as the bus address
  assign bus.imem_req    = (state == FETCH) || (state == DRAIN);
  assign bus.imem_addr   = pc;
  assign bus.inst_valid  = inst_valid_q;
  assign bus.instruction = instruction_q;
  assign bus.opcode      = instruction_q[DATA_WIDTH-1 -: 6];
  assign bus.inst_pc     = inst_pc_q;
  assign bus.pc_plus4    = pc_plus4_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Producer side of the opcode interface: fetches 32-bit MIPS instructions from instruction memory and hands instruction plus opcode to the decode/control stage over a valid/ready handshake.
- Holds the PC, sequences PC+4, and accepts branch/jump redirects from the execute stage.
- Sits between the instruction memory port and the decode stage of the processor.
- At most one memory request is outstanding; there is one output holding register.

Parameters:
- DATA_WIDTH, 32, instruction and address width.
- PC_RESET, 32'h0040_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  DATA_WIDTH  fetch address; always word-aligned.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in that cycle.
- imem_rdata  in  DATA_WIDTH  fetched instruction word.
- inst_valid  out  1  instruction output register holds a valid instruction.
- inst_ready  in  1  decode stage accepts the instruction this cycle.
- instruction  out  DATA_WIDTH  registered instruction word.
- opcode  out  6  instruction[31:26], feeds the control unit OP input.
- inst_pc  out  DATA_WIDTH  address of the registered instruction.
- pc_plus4  out  DATA_WIDTH  inst_pc + 4, modulo 2^32.
- redirect  in  1  one-cycle pulse from execute: branch taken or jump.
- redirect_target  in  DATA_WIDTH  new PC; bits [1:0] are ignored and forced to 00.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - state=IDLE, pc=PC_RESET, imem_req=0, imem_addr=PC_RESET.
  - inst_valid=0, instruction=0, inst_pc=0, pc_plus4=4.
  - Instruction memory shares this reset; no stale ack arrives after reset is released.
- States: IDLE, FETCH, DRAIN, HOLD.
  - imem_req = (state==FETCH || state==DRAIN).
  - imem_addr = pc in FETCH; in DRAIN it holds the address of the outstanding request.
- IDLE: unconditionally goes to FETCH on the first clk edge after reset is released. The first request is visible one cycle after release.
- FETCH:
  - imem_req and imem_addr stay stable until imem_ack. Ack may come in the same cycle the request is first presented (zero-wait memory) or any later cycle.
  - On ack without redirect: instruction<=imem_rdata, inst_pc<=pc, pc_plus4<=pc+4, pc<=pc+4, inst_valid<=1, state goes to HOLD.
  - On ack with redirect in the same cycle: data is discarded, pc<={target[31:2],2'b00}, state stays FETCH (new address on the next cycle).
  - On redirect without ack: latch the target into pending_target and go to DRAIN. The address stays unchanged.
- DRAIN:
  - Request stays asserted with the old address until ack.
  - A further redirect overwrites pending_target (latest wins).
  - On ack: data is discarded, inst_valid stays 0, pc<=pending_target (or the same-cycle redirect target if one is present), state goes to FETCH.
- HOLD:
  - inst_valid=1; instruction, opcode, inst_pc and pc_plus4 are stable while inst_ready=0.
  - imem_req=0 (no prefetch).
  - inst_valid && inst_ready: inst_valid<=0, state goes to FETCH at pc.
  - Redirect (with or without ready): inst_valid<=0, pc<=target, state goes to FETCH. If ready is also high, the instruction counts as consumed.
- Throughput is at most one instruction per 2 cycles with zero-wait memory.
- Arithmetic: PC increments wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
- opcode is combinational from the instruction register and is valid only when inst_valid=1.
- Reset asserted mid-DRAIN or mid-FETCH abandons the request. After release, fetching restarts from PC_RESET.

Test Plan:
- Release reset; zero-wait memory returns 32'h2008_0005 at ack → imem_req=1 with imem_addr=0x0040_0000 in cycle 1 after release; next cycle inst_valid=1, opcode=6'h08, inst_pc=0x0040_0000, pc_plus4=0x0040_0004; after ready, next imem_addr=0x0040_0004.
- inst_ready=0 for 3 cycles in HOLD → instruction, inst_pc and opcode unchanged; imem_req=0 throughout; no address advance.
- Ack delayed 3 cycles; redirect pulse to 0x0040_0020 in cycle 1 → imem_addr stays 0x0040_0000 until ack; returned word is never presented (inst_valid=0); next request addr=0x0040_0020.
- Redirect to 0x0040_0023 in HOLD with inst_ready=1 in the same cycle → inst_valid drops next cycle; next fetch addr=0x0040_0020.
- PC_RESET=32'hFFFF_FFFC, zero-wait memory → first addr 0xFFFF_FFFC, pc_plus4=0x0000_0000, second addr 0x0000_0000.
- Assert reset mid-DRAIN → inst_valid=0 and imem_req=0 immediately without a clk edge; after release, first address is PC_RESET.
